ibex_obi_arbiter: RTL and testbench
===================================

# ibex_obi_arbiter

Two-to-one OBI arbiter that lets the Ibex instruction-fetch and data ports share a single memory subordinate port (e.g. a single-ported boot/scratch SRAM). It sits between the core's imem/dmem interfaces and the shared memory. It arbitrates requests round-robin, holds the selection stable until grant, and routes each response back to the issuing port through an in-order ID FIFO.

## Interface
Parameters:
- MaxOutstanding, 2 — response-FIFO depth; power of two, 1..8.
- AddrWidth, 32 — address width.
- DataWidth, 32 — data width; byte enables are DataWidth/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- instr_req_i / instr_gnt_o / instr_addr_i[AddrWidth]  in/out/in — fetch request channel; read-only.
- instr_rvalid_o / instr_rdata_o[DataWidth] / instr_err_o  out — fetch response.
- data_req_i / data_gnt_o / data_addr_i[AddrWidth] / data_we_i / data_be_i[DataWidth/8] / data_wdata_i[DataWidth]  in/out/in/in/in/in — data request channel.
- data_rvalid_o / data_rdata_o[DataWidth] / data_err_o  out — data response.
- mem_req_o / mem_reqpar_o / mem_gnt_i / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out/out/in/out/out/out/out — shared subordinate request; mem_reqpar_o = ~mem_req_o.
- mem_rvalid_i / mem_rdata_i[DataWidth] / mem_err_i  in — shared subordinate response.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current FIFO occupancy.
- unexpected_rsp_o  out  1  sticky; set by mem_rvalid_i while the FIFO is empty.

## Operation
- Request path: one selected port drives mem_* combinationally. Instr selection forces mem_we_o=0, mem_be_o=all-ones, mem_wdata_o=0.
- Arbitration: when no request is locked and both req are high, the port not granted last wins (round-robin pointer, resets to "data wins first"). A single requester wins immediately.
- Lock: once a port is selected and mem_req_o is high without mem_gnt_i, the selection register holds until the handshake completes. The other port cannot preempt it.
- Grant: a handshake occurs when mem_req_o & mem_gnt_i. mem_gnt_i is forwarded combinationally to the selected port's gnt; the other gnt stays 0. On a handshake the winner's ID is pushed into the FIFO, the round-robin pointer advances, and the lock clears.
- Full: when occupancy == MaxOutstanding, mem_req_o=0 and both gnt=0. Requests wait.
- Response: mem_rvalid_i pops the FIFO head and routes rvalid/rdata/err to that port. The other port's rvalid is 0 and its rdata is 0.
- Simultaneous push and pop in one cycle: occupancy is unchanged. This is legal even when the FIFO is full: the pop frees the slot in the same cycle only if mem_rvalid_i is set, so mem_req_o may assert when full && mem_rvalid_i.
- Unexpected response: mem_rvalid_i with the FIFO empty is dropped and sets unexpected_rsp_o. Only reset clears it.
- FIFO pointers wrap modulo MaxOutstanding.

## Timing
- Request latency: 0 cycles, port req to mem_req_o combinational.
- Grant latency: 0 cycles, mem_gnt_i to the port gnt combinational.
- Response latency: 0 cycles, mem_rvalid_i to the port rvalid combinational.
- State updates on the rising clk_i edge: selection/lock, round-robin pointer, FIFO, occupancy and sticky flag.
- Reset (rst_i high at an edge): FIFO emptied, occupancy 0, lock cleared, pointer = data-first, unexpected_rsp_o=0.
- Reset effect on outputs: all gnt/rvalid/mem_req_o are 0 while rst_i is high. Responses in flight at reset are discarded; their later rvalid sets unexpected_rsp_o.
- Upstream must hold req/addr/wdata stable until gnt (OBI rule). The arbiter does not register request payloads.

## Configuration
- OBI_ARB_DATA_PRIO_EN defined: fixed priority; data always wins an unlocked conflict. The round-robin pointer is not implemented. Locking and the FIFO are unchanged.
- Not defined: round-robin as described above.

## Test plan
- Single fetch, addr 0x100, mem_gnt_i same cycle, rvalid next cycle with rdata 0xDEADBEEF -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with 0xDEADBEEF in cycle 1; data_rvalid_o=0 throughout.
- Both ports request continuously, mem_gnt_i always 1, rvalid 1 cycle later -> grants alternate D,I,D,I…; each response is routed to its issuer; outstanding_o ≤ 1.
- mem_gnt_i held low 3 cycles while instr is selected, then data raises req -> mem_addr_o stays the instr address until the grant; data is granted on the next handshake.
- MaxOutstanding=2, grants with rvalid delayed 5 cycles -> after 2 handshakes mem_req_o=0 and outstanding_o=2; first rvalid re-enables the request in the same cycle; responses are returned in order.
- mem_rvalid_i pulse with the FIFO empty -> no port rvalid; unexpected_rsp_o=1 until rst_i.
- rst_i asserted with 2 outstanding -> next cycle outstanding_o=0 and all outputs 0; with OBI_ARB_DATA_PRIO_EN defined, a repeated conflict grants data every time.

Source files
------------

// File: rtl/ibex_obi_arbiter.sv
// ibex_obi_arbiter: shares one OBI memory port between Ibex instr-fetch and data ports.
// Latency: 0 cycles on every path (req->mem_req, mem_gnt->port gnt, mem_rvalid->port rvalid).
// Backpressure: selection locks until mem_gnt; requests stall while the response-ID FIFO is full.
// Build option: define OBI_ARB_DATA_PRIO_EN for fixed data-first priority instead of round-robin.

// Small in-order FIFO holding the port ID of each accepted request.
// Push and pop may happen together even when full: the popped slot is reused in the same cycle.
module ibex_obi_arbiter_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Pointers wrap at Depth-1 so non-trivial depths index only valid slots.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_i) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Control state is reset; payload storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage update.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;

endmodule

module ibex_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // Instruction fetch port (read-only)
  input  logic                   instr_req_i,
  output logic                   instr_gnt_o,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  // Data port
  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  // Shared memory port
  output logic                   mem_req_o,
  output logic                   mem_reqpar_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
  // Status
  output logic [CntW-1:0]        outstanding_o,
  output logic                   unexpected_rsp_o
);

  localparam logic IdInstr = 1'b0;
  localparam logic IdData  = 1'b1;

  // Lock holds the selected port from first mem_req_o until its handshake.
  logic lock_q, lock_d;
  logic sel_q, sel_d;
  logic unexp_q, unexp_d;

  logic sel;
  logic conflict_winner;
  logic sel_req;
  logic can_issue;
  logic hs;
  logic pop;
  logic fifo_empty;
  logic fifo_full;
  logic fifo_head;
  logic [CntW-1:0] fifo_cnt;

`ifdef OBI_ARB_DATA_PRIO_EN
  // Data always wins an unlocked conflict; no round-robin state exists.
  assign conflict_winner = IdData;
`else
  // Port granted last; resetting to instr makes data win the first conflict.
  logic last_q, last_d;

  assign conflict_winner = ~last_q;

  // Round-robin pointer follows the port of each completed handshake.
  always_comb begin
    last_d = last_q;
    if (hs) begin
      last_d = sel;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IdInstr;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Port selection: a locked port keeps the bus; otherwise arbitrate live requests.
  always_comb begin
    sel = IdData;
    if (lock_q) begin
      sel = sel_q;
    end else if (instr_req_i && data_req_i) begin
      sel = conflict_winner;
    end else if (instr_req_i) begin
      sel = IdInstr;
    end else begin
      sel = IdData;
    end
  end

  assign sel_req = (sel == IdData) ? data_req_i : instr_req_i;

  // A response retiring this cycle frees a FIFO slot for a same-cycle push.
  assign pop       = mem_rvalid_i & ~fifo_empty & ~rst_i;
  assign can_issue = ~fifo_full | pop;

  assign mem_req_o    = ~rst_i & sel_req & can_issue;
  assign mem_reqpar_o = ~mem_req_o;
  assign hs           = mem_req_o & mem_gnt_i;

  assign instr_gnt_o = hs & (sel == IdInstr);
  assign data_gnt_o  = hs & (sel == IdData);

  // Request payload mux; fetches are forced to full-word reads.
  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_wdata_o = '0;
    if (sel == IdData) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  ibex_obi_arbiter_fifo #(
    .Depth (MaxOutstanding),
    .Width (1)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .wdata_i (sel),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  // Response routing to the port at the FIFO head; the idle port sees zeros.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;
    if (pop) begin
      if (fifo_head == IdData) begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = mem_rdata_i;
        data_err_o    = mem_err_i;
      end else begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mem_rdata_i;
        instr_err_o    = mem_err_i;
      end
    end
  end

  // Lock/selection and sticky unexpected-response flag next state.
  always_comb begin
    lock_d  = lock_q;
    sel_d   = sel_q;
    unexp_d = unexp_q;
    if (hs) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d = 1'b1;
      sel_d  = sel;
    end
    if (mem_rvalid_i && fifo_empty) begin
      unexp_d = 1'b1;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q  <= 1'b0;
      sel_q   <= IdData;
      unexp_q <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      sel_q   <= sel_d;
      unexp_q <= unexp_d;
    end
  end

  assign outstanding_o    = fifo_cnt;
  assign unexpected_rsp_o = unexp_q;

endmodule

// File: tb/tb_ibex_obi_arbiter.sv
`timescale 1ns/1ps
module tb_ibex_obi_arbiter;

  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);

`ifdef OBI_ARB_DATA_PRIO_EN
  localparam bit DataPrio = 1'b1;
`else
  localparam bit DataPrio = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]   instr_addr_i, instr_rdata_o;
  logic          data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [31:0]   data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]    data_be_i;
  logic          mem_req_o, mem_reqpar_o, mem_gnt_i, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]    mem_be_o;
  logic          mem_rvalid_i, mem_err_i;
  logic [CW-1:0] outstanding_o;
  logic          unexpected_rsp_o;

  always #5 clk_i = ~clk_i;

  ibex_obi_arbiter #(.MaxOutstanding(MO), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_reqpar_o(mem_reqpar_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o), .unexpected_rsp_o(unexpected_rsp_o)
  );

  typedef struct packed {
    logic        port;   // 1 = data, 0 = instr
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];   // expected responses, in issue order
  rsp_t pend_q[$];  // responses the memory model still owes
  int   errors = 0;
  int   checks = 0;
  int   rd_seq = 0;
  logic exp_unexp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle. exp_w: -1 no mem_req expected, 0 instr selected, 1 data selected.
  task automatic do_cycle(input logic ireq, input logic dreq, input logic gnt, input logic rv,
                          input int exp_w, input int exp_occ);
    rsp_t r;
    rsp_t n;
    logic stray;
    stray        = 1'b0;
    instr_req_i  = ireq;
    data_req_i   = dreq;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = 32'h1234_5678;
    mem_err_i    = 1'b0;
    if (rv) begin
      if (pend_q.size() > 0) begin
        r           = pend_q.pop_front();
        mem_rdata_i = r.rdata;
        mem_err_i   = r.err;
      end else begin
        stray = 1'b1;
      end
    end
    @(negedge clk_i);
    chk("mem_req", mem_req_o, exp_w >= 0);
    chk("mem_reqpar", mem_reqpar_o, exp_w < 0);
    chk("occupancy", outstanding_o, exp_occ);
    chk("unexpected_flag", unexpected_rsp_o, exp_unexp);
    if (!rv || stray) begin
      chk("instr_rvalid_idle", instr_rvalid_o, 1'b0);
      chk("data_rvalid_idle", data_rvalid_o, 1'b0);
    end
    if (stray) begin
      chk("instr_rdata_stray", instr_rdata_o, 32'h0);
      chk("data_rdata_stray", data_rdata_o, 32'h0);
      exp_unexp = 1'b1;
    end
    if (exp_w >= 0) begin
      chk("mem_addr", mem_addr_o, (exp_w == 1) ? data_addr_i : instr_addr_i);
      chk("mem_we", mem_we_o, (exp_w == 1) ? data_we_i : 1'b0);
      chk("mem_be", mem_be_o, (exp_w == 1) ? data_be_i : 4'hF);
      chk("mem_wdata", mem_wdata_o, (exp_w == 1) ? data_wdata_i : 32'h0);
    end
    chk("instr_gnt", instr_gnt_o, gnt && (exp_w == 0));
    chk("data_gnt", data_gnt_o, gnt && (exp_w == 1));
    if (gnt && exp_w >= 0) begin
      rd_seq++;
      n.port  = (exp_w == 1);
      n.rdata = (rd_seq == 1) ? 32'hDEAD_BEEF : (32'hC0DE_0000 + 32'(rd_seq));
      n.err   = (rd_seq % 3 == 0);
      exp_q.push_back(n);
      pend_q.push_back(n);
    end
    @(posedge clk_i);
    #1;
  endtask

  // Hold reset with hostile inputs; everything visible must stay quiet.
  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      rst_i        = 1'b1;
      instr_req_i  = 1'b1;
      data_req_i   = 1'b1;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      @(negedge clk_i);
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_instr_gnt", instr_gnt_o, 1'b0);
      chk("rst_data_gnt", data_gnt_o, 1'b0);
      chk("rst_instr_rvalid", instr_rvalid_o, 1'b0);
      chk("rst_data_rvalid", data_rvalid_o, 1'b0);
      if (i > 0) begin
        chk("rst_occupancy", outstanding_o, 0);
        chk("rst_unexpected", unexpected_rsp_o, 1'b0);
      end
      @(posedge clk_i);
      #1;
    end
    exp_q.delete();
    pend_q.delete();
    exp_unexp    = 1'b0;
    rst_i        = 1'b0;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  // Monitor: every port response must match the oldest expected entry.
  always @(negedge clk_i) begin
    rsp_t e;
    if (instr_rvalid_o || data_rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("rsp_without_request", {instr_rvalid_o, data_rvalid_o}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_instr_rvalid", instr_rvalid_o, !e.port);
        chk("rsp_data_rvalid", data_rvalid_o, e.port);
        chk("rsp_rdata", e.port ? data_rdata_o : instr_rdata_o, e.rdata);
        chk("rsp_err", e.port ? data_err_o : instr_err_o, e.err);
        chk("rsp_other_rdata", e.port ? instr_rdata_o : data_rdata_o, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = 32'h100;
    data_req_i = 1'b0; data_addr_i = 32'h300; data_we_i = 1'b1;
    data_be_i = 4'h3; data_wdata_i = 32'hA5A5_5A5A;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    #1;
    do_reset(2);

    // Single fetch at 0x100, granted at once, answered next cycle with 0xDEADBEEF.
    do_cycle(1, 0, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 1, -1, 1);
    do_cycle(0, 0, 0, 0, -1, 0);

    // Continuous conflict: data, instr, data, ... (data every time with fixed priority).
    instr_addr_i = 32'h200;
    for (int k = 0; k < 6; k++) begin
      do_cycle(1, 1, 1, k > 0, DataPrio ? 1 : ((k % 2 == 0) ? 1 : 0), (k > 0) ? 1 : 0);
    end
    do_cycle(0, 0, 0, 1, -1, 1);
    do_cycle(0, 0, 0, 0, -1, 0);

    // Lock: instr stalled 3 cycles, data arrives meanwhile but cannot preempt.
    instr_addr_i = 32'h400; data_addr_i = 32'h500;
    do_cycle(1, 0, 0, 0, 0, 0);
    do_cycle(1, 1, 0, 0, 0, 0);
    do_cycle(1, 1, 0, 0, 0, 0);
    do_cycle(1, 1, 1, 0, 0, 0);
    do_cycle(0, 1, 1, 1, 1, 1);
    do_cycle(0, 0, 0, 1, -1, 1);

    // FIFO full: two handshakes, stall, first response 5 cycles later re-enables the request.
    instr_addr_i = 32'h600; data_addr_i = 32'h700; data_we_i = 1'b0; data_be_i = 4'hF;
    do_cycle(1, 1, 1, 0, DataPrio ? 1 : 0, 0);
    do_cycle(1, 1, 1, 0, 1, 1);
    do_cycle(1, 1, 1, 0, -1, 2);
    do_cycle(1, 1, 1, 0, -1, 2);
    do_cycle(1, 1, 1, 0, -1, 2);
    do_cycle(1, 1, 1, 1, DataPrio ? 1 : 0, 2);
    do_cycle(0, 0, 0, 1, -1, 2);
    do_cycle(0, 0, 0, 1, -1, 1);
    do_cycle(0, 0, 0, 0, -1, 0);

    // Response with nothing outstanding: dropped, sticky flag raised.
    do_cycle(0, 0, 0, 1, -1, 0);
    do_cycle(0, 0, 0, 0, -1, 0);
    do_cycle(0, 0, 0, 0, -1, 0);

    // Reset with two requests in flight; their late response counts as unexpected.
    instr_addr_i = 32'h800;
    do_cycle(1, 0, 1, 0, 0, 0);
    do_cycle(1, 0, 1, 0, 0, 1);
    do_reset(1);
    do_cycle(0, 0, 0, 0, -1, 0);
    do_cycle(0, 0, 0, 1, -1, 0);
    do_cycle(0, 0, 0, 0, -1, 0);

    // Pointer is data-first again after reset.
    data_we_i = 1'b1; data_be_i = 4'hC; data_wdata_i = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      do_cycle(1, 1, 1, k > 0, DataPrio ? 1 : ((k % 2 == 0) ? 1 : 0), (k > 0) ? 1 : 0);
    end
    do_cycle(0, 0, 0, 1, -1, 1);
    do_cycle(0, 0, 0, 0, -1, 0);

    chk("responses_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
